// File: rtl/load_store_unit_pkg.sv
// Shared encodings and types for the load/store unit.
package load_store_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} lsu_state_e;

   // Request fields captured at acceptance.
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // Size 3, odd halfword or non-word-aligned word.
   function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] off);
      return (size == SZ_ILL) ||
             ((size == SZ_HALF) && off[0]) ||
             ((size == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane extraction for loads and lane merge for stores.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] new_data,
   output logic [31:0] extracted,
   output logic [31:0] merged
);

   logic [7:0]  b;
   logic [15:0] h;

   assign b = word[{offset, 3'b000} +: 8];
   assign h = word[{offset[1], 4'b0000} +: 16];

   // Word size passes straight through; sub-word sizes touch only their lane.
   always_comb begin
      extracted = word;
      merged    = new_data;
      case (size)
         SZ_BYTE: begin
            extracted = {{24{is_signed & b[7]}}, b};
            merged    = word;
            merged[{offset, 3'b000} +: 8] = new_data[7:0];
         end
         SZ_HALF: begin
            extracted = {{16{is_signed & h[15]}}, h};
            merged    = word;
            merged[{offset[1], 4'b0000} +: 16] = new_data[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word accesses to a word-wide
// data memory, sub-word stores done as read-modify-write.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state, state_nxt;
   lsu_req_t    req_q;
   logic        err_q;
   logic [31:0] word_q;
   logic [31:0] ld_val;
   logic [31:0] st_word;
   logic        acc;
   logic        ill;

   assign acc = (state == IDLE) && req_valid;
   assign ill = access_illegal(req_size, req_addr[1:0]);

   lsu_lane_align u_align (
      .word      (word_q),
      .offset    (req_q.addr[1:0]),
      .size      (req_q.size),
      .is_signed (req_q.sgn),
      .new_data  (req_q.wdata),
      .extracted (ld_val),
      .merged    (st_word)
   );

   // Next-state: errors skip memory, word stores skip the read.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (ill)                     state_nxt = DONE;
               else if (!req_we)            state_nxt = RD;
               else if (req_size == SZ_WORD) state_nxt = WR;
               else                         state_nxt = RD;
            end
         end
         RD:      state_nxt = req_q.we ? WR : DONE;
         WR:      state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Latch request on accept; capture the memory word at the end of RD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q  <= '0;
         err_q  <= 1'b0;
         word_q <= '0;
      end else begin
         if (acc) begin
            req_q <= '{we: req_we, size: req_size, sgn: req_signed,
                       addr: req_addr, wdata: req_wdata};
            err_q <= ill;
         end
         if (state == RD) word_q <= mem_rdata;
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == DONE);
   assign rsp_err   = (state == DONE) && err_q;
   assign rsp_rdata = ((state == DONE) && !req_q.we && !err_q) ? ld_val : 32'h0;
   assign mem_addr  = (state == IDLE) ? {req_addr[31:2], 2'b00} : {req_q.addr[31:2], 2'b00};
   assign mem_we    = (state == WR);
   // Merged word equals wdata for word stores, so one path serves both.
   assign mem_wdata = st_word;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a word-array reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] dmem [0:1023] = '{default: 32'h0};
   logic [31:0] ref_mem [0:1023];
   int total = 0;
   int bad = 0;
   int we_cnt = 0;

   load_store_unit dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Data memory: asynchronous read, write on rising edge.
   assign mem_rdata = dmem[mem_addr[11:2]];
   always @(posedge clk) begin
      if (mem_we) begin
         dmem[mem_addr[11:2]] <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One access from IDLE (called just after a falling edge). Expected
   // behaviour comes from arithmetic on the reference word array.
   task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic garble, output logic [31:0] got_rd);
      logic [9:0]  idx;
      logic        ill;
      logic [31:0] exp_rd, new_word;
      longint unsigned lw, lv, mask, v;
      int nb, sh, lat, exp_w, w0, n;
      logic seen;
      idx = a[11:2];
      lw  = 64'(ref_mem[idx]);
      lv  = 64'(wd);
      ill = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
      nb  = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
      sh  = 8 * int'(a[1:0]);
      mask = (64'd1 << nb) - 64'd1;
      exp_rd = 32'h0;
      new_word = ref_mem[idx];
      if (!ill) begin
         if (we) new_word = 32'((lw & ~(mask << sh)) | ((lv & mask) << sh));
         else begin
            v = (lw >> sh) & mask;
            if (sg && v[nb-1]) v = v | ~mask;
            exp_rd = v[31:0];
         end
      end
      lat   = ill ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
      exp_w = (!ill && we) ? 1 : 0;

      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      #1;
      chk("ready_idle", 32'(req_ready), 32'd1);
      chk("maddr_idle", mem_addr, {a[31:2], 2'b00});
      w0 = we_cnt;
      seen = 1'b0; n = 0;
      for (int c = 1; c <= 6 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = 1'b0;
            if (garble) begin
               req_addr = $urandom; req_wdata = $urandom;
               req_we = ~we; req_size = 2'($urandom_range(0, 3));
            end
         end
         #1;
         chk("maddr_busy", mem_addr, {a[31:2], 2'b00});
         chk("ready_busy", 32'(req_ready), 32'd0);
         if (rsp_valid) begin seen = 1'b1; n = c; end
      end
      chk("rsp_seen", 32'(seen), 32'd1);
      chk("latency", n, lat);
      chk("rdata", rsp_rdata, exp_rd);
      chk("err", 32'(rsp_err), 32'(ill));
      got_rd = rsp_rdata;
      @(negedge clk); #1;
      chk("rsp_single", 32'(rsp_valid), 32'd0);
      chk("ready_back", 32'(req_ready), 32'd1);
      chk("we_count", we_cnt - w0, exp_w);
      ref_mem[idx] = new_word;
      chk("mem_word", dmem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [31:0] rd;
      int r, w0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

      // Reset state, with mem_addr tracking req_addr word-aligned.
      req_addr = 32'h0000_1237;
      #2;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_maddr", mem_addr, 32'h0000_1234);
      @(negedge clk);
      reset_n = 1'b1;

      // Word store then word load.
      access(1'b1, 2'd2, 1'b0, 32'h3FFC, 32'hDEADBEEF, 1'b0, rd);
      access(1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0, 1'b1, rd);
      chk("spec_wload", rd, 32'hDEADBEEF);

      // Byte store over 0x11223344 then signed/unsigned byte loads.
      access(1'b1, 2'd2, 1'b0, 32'h3FFC, 32'h11223344, 1'b0, rd);
      access(1'b1, 2'd0, 1'b0, 32'h3FFD, 32'h000000AA, 1'b1, rd);
      chk("spec_bstore", dmem[10'h3FF], 32'h1122AA44);
      access(1'b0, 2'd0, 1'b1, 32'h3FFD, 32'h0, 1'b0, rd);
      chk("spec_bload_s", rd, 32'hFFFFFFAA);
      access(1'b0, 2'd0, 1'b0, 32'h3FFD, 32'h0, 1'b0, rd);
      chk("spec_bload_u", rd, 32'h000000AA);

      // Halfword store over 0x11223344 then signed halfword load.
      access(1'b1, 2'd2, 1'b0, 32'h3FFC, 32'h11223344, 1'b0, rd);
      access(1'b1, 2'd1, 1'b0, 32'h3FFE, 32'h00008001, 1'b0, rd);
      chk("spec_hstore", dmem[10'h3FF], 32'h80013344);
      access(1'b0, 2'd1, 1'b1, 32'h3FFE, 32'h0, 1'b1, rd);
      chk("spec_hload_s", rd, 32'hFFFF8001);

      // Illegal accesses: error, one-cycle latency, no write.
      access(1'b1, 2'd1, 1'b0, 32'h3FFD, 32'h12345678, 1'b0, rd);
      access(1'b0, 2'd1, 1'b1, 32'h3FFD, 32'h0, 1'b0, rd);
      access(1'b1, 2'd2, 1'b0, 32'h3FFE, 32'h12345678, 1'b1, rd);
      access(1'b0, 2'd3, 1'b0, 32'h3FFC, 32'h0, 1'b0, rd);
      access(1'b1, 2'd3, 1'b0, 32'h3FFC, 32'hCAFEF00D, 1'b0, rd);
      chk("spec_err_mem", dmem[10'h3FF], 32'h80013344);

      // Reset pulse during RD of a byte store aborts it.
      w0 = we_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h3FFD; req_wdata = 32'h55;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("abort_in_rd", 32'(req_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_err", 32'(rsp_err), 32'd0);
      chk("abort_rdata", rsp_rdata, 32'h0);
      chk("abort_we", 32'(mem_we), 32'd0);
      #1;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("abort_ready2", 32'(req_ready), 32'd1);
      chk("abort_wecnt", we_cnt - w0, 32'd0);
      chk("abort_mem", dmem[10'h3FF], 32'h80013344);

      // req_valid held high: accepts only in IDLE, single-cycle responses.
      w0 = we_cnt;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h3FFC;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk); #1;
         chk("hold_ready", 32'(req_ready), 32'((k % 3) == 0));
         chk("hold_rsp", 32'(rsp_valid), 32'((k % 3) == 2));
         if (rsp_valid) chk("hold_rdata", rsp_rdata, ref_mem[10'h3FF]);
      end
      req_valid = 1'b0;
      chk("hold_wecnt", we_cnt - w0, 32'd0);

      // Randomized mix over a small window so accesses collide.
      for (int i = 0; i < 60; i++) begin
         logic [1:0] sz;
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                32'h3FE0 + 32'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be none; all widths are fixed at 32-bit data and address.
REQ-002 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  CPU presents an access.
REQ-005 req_ready  out  1  unit can accept an access; high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-008 req_signed  in  1  sign-extend sub-word loads when 1.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  load result, zero or sign extended; 0 for stores and errors.
REQ-013 rsp_err  out  1  misaligned or illegal-size access, valid with rsp_valid.
REQ-014 mem_addr  out  32  word address to data memory, {addr[31:2],2'b00}.
REQ-015 mem_we  out  1  data memory write enable.
REQ-016 mem_wdata  out  32  full word written to data memory.
REQ-017 mem_rdata  in  32  data memory asynchronous read data for mem_addr.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR and DONE; an access is accepted on a rising edge with req_valid=1 in IDLE, latching we, size, signed, addr and wdata.
REQ-019 Accepted illegal access SHALL go IDLE->DONE: size 3, halfword with addr[0]=1, or word with addr[1:0]!=0; rsp_err=1, no mem_we.
REQ-020 Legal load SHALL go IDLE->RD->DONE; mem_rdata is captured at the end of RD; rsp_valid is asserted 2 cycles after acceptance.
REQ-021 Word store SHALL go IDLE->WR->DONE; mem_we=1 for exactly the WR cycle with mem_wdata=wdata.
REQ-022 Byte or halfword store SHALL go IDLE->RD->WR->DONE (read-modify-write); WR writes the captured word with only the addressed lane(s) replaced.
REQ-023 Lanes SHALL be little-endian: byte k occupies bits [8k+7:8k] for k=addr[1:0]; a halfword at addr[1]=h occupies bits [16h+15:16h].
REQ-024 DONE SHALL last exactly one cycle with rsp_valid=1 and then return to IDLE; req_ready=0 in RD, WR and DONE, so back-to-back accesses are spaced by at least one idle cycle.
REQ-025 mem_addr SHALL hold the latched word address from RD through DONE; in IDLE it SHALL track req_addr word-aligned.
REQ-026 mem_we SHALL be 0 in every state other than WR.
REQ-027 req_* changes while not in IDLE SHALL be ignored.

Reset
REQ-028 Asserting reset_n=0 SHALL force IDLE immediately, with req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0 and mem_we=0, and clear all latched request registers.
REQ-029 Reset during RD or WR SHALL abort the access; a write is not completed if reset precedes the WR rising edge.

Structure
REQ-030 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-031 Lane extraction/merge SHALL be a combinational sub-module named lsu_lane_align (inputs: word, offset, size, signed, new data; outputs: extracted value, merged word).

Verification
REQ-032 The bench SHALL cover these scenarios:
- Word store 0xDEADBEEF to 0x3FFC, then word load from 0x3FFC -> one mem_we pulse; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
- Byte store 0xAA to 0x3FFD over 0x11223344 -> mem_wdata=0x1122AA44 in WR; signed byte load from 0x3FFD -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Halfword store 0x8001 to 0x3FFE over 0x11223344 -> 0x80013344; signed halfword load from 0x3FFE -> 0xFFFF8001.
- Halfword at 0x3FFD, word at 0x3FFE and size=3 -> rsp_err=1, rsp_valid 1 cycle after accept, mem_we never asserted, memory unchanged.
- reset_n pulsed low during RD of a byte store -> IDLE, req_ready=1, no mem_we, memory word unchanged.
- req_valid held high continuously -> accepts only in IDLE; each rsp_valid is a single cycle.
